ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the 64x8 single-port `ram`. Two independent requesters issue read/write accesses. The block grants at most one access per clock, drives the RAM's `data`/`addr`/`write` inputs, and returns read data from `q` to the requester that issued the read, with a fixed pipelined latency. It sits directly in front of one `ram` instance and is the only driver of its inputs.

## Interface
- `DATA_W`, default 8: data width; must match the RAM word.
- `ADDR_W`, default 6: address width (64 words).
- `clk` in 1: rising-edge clock, shared with `ram`.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: access request, held until granted.
- `we0` / `we1` in 1: 1 = write, 0 = read; valid while `reqN` is high.
- `addr0` / `addr1` in `ADDR_W`: access address.
- `wdata0` / `wdata1` in `DATA_W`: write data.
- `gnt0` / `gnt1` out 1: combinational grant. The access is accepted at the rising edge where `reqN && gntN`.
- `rvalid0` / `rvalid1` out 1: registered one-cycle pulse; `rdataN` holds the read result.
- `rdata0` / `rdata1` out `DATA_W`: registered read data, held until the next completed read for that port.
- `ram_data` out `DATA_W`: to `ram.data`.
- `ram_addr` out `ADDR_W`: to `ram.addr`.
- `ram_write` out 1: to `ram.write`.
- `ram_q` in `DATA_W`: from `ram.q`. `ram.q` is registered and updates at the edge that samples `addr`.

## Operation
- Grant logic:
  - Only one requesting port: that port wins.
  - Both requesting: winner chosen by the priority policy (see Configuration).
  - Neither requesting: no grant.
- While `rst` is high, `gnt0 = gnt1 = 0`.
- RAM mux (combinational):
  - Granted port N: `ram_addr = addrN`, `ram_data = wdataN`, `ram_write = weN`.
  - No grant: `ram_addr = 0`, `ram_data = 0`, `ram_write = 0`. No spurious writes ever occur.
- State:
  - `last`: 1-bit index of the most recently granted port; updates only on a grant.
  - `rd_pend`: valid bit plus port id of a read accepted at the previous edge.
  - `rdata0` / `rdata1` holding registers.
- Read completion: at the edge after a read is accepted, `ram_q` is captured into `rdataN` of the pending port and `rvalidN` goes high for exactly one cycle.
- Writes produce no `rvalid`.
- Back-to-back reads from either or both ports are fully pipelined: one completion per cycle, completed in issue order.
- A read following a write to the same address returns the new data, since the accesses are serialized in the RAM.
- Reset values: `last = 1` (port 0 wins the first contention), `rd_pend` invalid, `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0`.
- Reset asserted mid-read: the pending read is discarded, no `rvalid` is produced, and `rdata` is cleared.

## Timing
- Grant: same cycle as `req`, combinational from `req0`, `req1` and `last`.
- Write: takes effect at the accepting edge E0.
- Read latency:
  - Accepting edge E0: RAM samples `addr`; `q` is valid after E0.
  - E1: arbiter captures `ram_q`.
  - `rvalidN` and `rdataN` are valid in the cycle after E1, i.e. 2 edges from acceptance.
- Throughput: 1 access per cycle total.
- Round-robin guarantees each continuously requesting port a grant at least every 2 cycles.
- `req` dropped before a grant: the access is withdrawn; no state change.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined:
  - Port 0 always wins contention; `last` is still maintained but ignored.
  - Port 1 can be starved indefinitely.
- `RAM_ARB_FIXED_PRIO_EN` undefined (default):
  - Round-robin; on contention the port other than `last` wins.

## Test plan
- Reset: hold `rst = 1` for 3 cycles with `req0 = req1 = 1` → `gnt0 = gnt1 = 0`, `ram_write = 0`, `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0x00`.
- Single-port write/read:
  - Port 0 writes `0x01`@0, `0x02`@1, `0x03`@3, then reads @0 and @1 back-to-back.
  - Expect `rvalid0` pulses 2 cycles after each read acceptance, with `rdata0 = 0x01` then `0x02`, on consecutive cycles.
- Contention, round-robin (macro undefined):
  - Both ports continuously read distinct addresses holding `0xA0` (port 0) and `0xB1` (port 1).
  - Expect grants alternating 0, 1, 0, 1…, port 0 first after reset, and `rvalid0` / `rvalid1` alternating with the matching data.
- Contention, fixed priority (macro defined): same stimulus → `gnt0` every cycle, `gnt1` never, `rvalid1` never.
- Cross-port coherence:
  - Port 1 writes `0x5A`@10 and port 0 reads @10 in the following cycle.
  - Expect `rdata0 = 0x5A`.
- Reset mid-read:
  - Assert `rst` asynchronously one cycle after a port 1 read is accepted.
  - Expect no `rvalid1` pulse, `rdata1 = 0x00`, and the first contention after release granted to port 0.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port request arbiter and sequencer for a 64x8 single-port RAM
//            with registered read data returned to the issuing port.
// Options  : RAM_ARB_FIXED_PRIO_EN -- port 0 always wins contention
//            (default: round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_q
);

   logic              last_q, last_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_port_q, rd_port_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              w_gnt0, w_gnt1;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         w_gnt0 = req0;
         w_gnt1 = req1 & ~req0;
`else
         // On contention the port that did not win last time is served.
         w_gnt0 = req0 & (~req1 | last_q);
         w_gnt1 = req1 & (~req0 | ~last_q);
`endif
      end
   end

   always_comb begin
      ram_addr  = '0;
      ram_data  = '0;
      ram_write = 1'b0;
      if (w_gnt0) begin
         ram_addr  = addr0;
         ram_data  = wdata0;
         ram_write = we0;
      end else if (w_gnt1) begin
         ram_addr  = addr1;
         ram_data  = wdata1;
         ram_write = we1;
      end
   end

   always_comb begin
      last_d    = last_q;
      if (w_gnt0) last_d = 1'b0;
      if (w_gnt1) last_d = 1'b1;
      rd_pend_d = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);
      rd_port_d = w_gnt1;
      // ram_q now holds the word addressed at the previous (accepting) edge.
      rvalid0_d = rd_pend_q & ~rd_port_q;
      rvalid1_d = rd_pend_q &  rd_port_q;
      rdata0_d  = rvalid0_d ? ram_q : rdata0_q;
      rdata1_d  = rvalid1_d ? ram_q : rdata1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q    <= 1'b1;
         rd_pend_q <= 1'b0;
         rd_port_q <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         last_q    <= last_d;
         rd_pend_q <= rd_pend_d;
         rd_port_q <= rd_port_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign gnt0    = w_gnt0;
   assign gnt1    = w_gnt1;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Scoreboard bench for ram_arbiter driving a behavioural 64x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, we0, we1;
   logic [5:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata0, rdata1;
   logic [7:0] ram_data;
   logic [5:0] ram_addr;
   logic       ram_write;
   logic [7:0] ram_q;

   always #5 clk = ~clk;

   ram_arbiter #(.DATA_W(8), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_write(ram_write),
      .ram_q(ram_q)
   );

   // Behavioural single-port RAM with registered output.
   logic [7:0] ram_mem [64];
   initial for (int i = 0; i < 64; i++) ram_mem[i] = 8'h00;
   always @(posedge clk) begin
      if (ram_write) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_mem[ram_addr];
   end

   typedef struct {
      bit         port;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [64];
   int         cyc = 0;
   int         n_pass = 0;
   int         n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // One clock of stimulus; eg0/eg1 are the hand-computed expected grants.
   task automatic cycle(input bit r0, input bit w0, input logic [5:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [5:0] a1, input logic [7:0] d1,
                        input bit eg0, input bit eg1, input string tag);
      exp_t e;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      check({tag, " gnt0"}, gnt0, eg0);
      check({tag, " gnt1"}, gnt1, eg1);
      if (eg0 || eg1) begin
         check({tag, " ram_addr"}, ram_addr, eg0 ? a0 : a1);
         check({tag, " ram_write"}, ram_write, eg0 ? w0 : w1);
         if (eg0 ? w0 : w1) begin
            check({tag, " ram_data"}, ram_data, eg0 ? d0 : d1);
            model[eg0 ? a0 : a1] = eg0 ? d0 : d1;
         end else begin
            e.port = eg1;
            e.data = model[eg0 ? a0 : a1];
            e.cyc  = cyc + 2;
            sb.push_back(e);
         end
      end else begin
         check({tag, " idle ram_write"}, ram_write, 1'b0);
      end
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (rvalid0 || rvalid1)) begin
         if (rvalid0 && rvalid1) check("dual rvalid", 1, 0);
         if (sb.size() == 0) begin
            check("unexpected rvalid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("rvalid port", rvalid1, e.port);
            check("rdata", e.port ? rdata1 : rdata0, e.data);
            check("read latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      repeat (3) begin
         @(negedge clk);
         check("reset gnt0", gnt0, 0);
         check("reset gnt1", gnt1, 0);
         check("reset ram_write", ram_write, 0);
         check("reset rvalid", {rvalid0, rvalid1}, 0);
         check("reset rdata", {rdata0, rdata1}, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

      cycle(1, 1, 6'd0, 8'h01, 0, 0, 6'd0, 8'h00, 1, 0, "wr0");
      cycle(1, 1, 6'd1, 8'h02, 0, 0, 6'd0, 8'h00, 1, 0, "wr1");
      cycle(1, 1, 6'd3, 8'h03, 0, 0, 6'd0, 8'h00, 1, 0, "wr3");
      cycle(1, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, "rd0");
      cycle(1, 0, 6'd1, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, "rd1");

      cycle(1, 1, 6'd20, 8'hA0, 0, 0, 6'd0, 8'h00, 1, 0, "pre20");
      cycle(0, 0, 6'd0, 8'h00, 1, 1, 6'd21, 8'hB1, 0, 1, "pre21");
      for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         cycle(1, 0, 6'd20, 8'h00, 1, 0, 6'd21, 8'h00, 1, 0, "contend");
`else
         cycle(1, 0, 6'd20, 8'h00, 1, 0, 6'd21, 8'h00, (i % 2) == 0, (i % 2) == 1, "contend");
`endif
      end

      cycle(0, 0, 6'd0, 8'h00, 1, 1, 6'd10, 8'h5A, 0, 1, "xwr");
      cycle(1, 0, 6'd10, 8'h00, 0, 0, 6'd0, 8'h00, 1, 0, "xrd");
      repeat (3) @(negedge clk);

      cycle(0, 0, 6'd0, 8'h00, 1, 0, 6'd21, 8'h00, 0, 1, "rd_abort");
      #2;
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check("abort rvalid1", rvalid1, 0);
      check("abort rdata1", rdata1, 8'h00);
      check("abort rdata0", rdata0, 8'h00);
      repeat (2) begin
         @(negedge clk);
         check("abort rvalid1 held", rvalid1, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(1, 0, 6'd20, 8'h00, 1, 0, 6'd21, 8'h00, 1, 0, "post_rst");
`ifdef RAM_ARB_FIXED_PRIO_EN
      cycle(1, 0, 6'd20, 8'h00, 1, 0, 6'd21, 8'h00, 1, 0, "post_rst2");
`else
      cycle(1, 0, 6'd20, 8'h00, 1, 0, 6'd21, 8'h00, 0, 1, "post_rst2");
`endif

      repeat (4) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
